pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch-stage program counter block for the RV32i pipeline.
- Holds the current instruction address in a register and computes PC+4 with an internal combinational adder.
- Selects the next PC from sequential increment, branch/jump redirect, or hold (stall).
- Drives the instruction-memory address and the PC+4 value passed down the pipeline.

Parameters:
- XLEN, 32, datapath/address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INCREMENT, 4, sequential step added to PC each enabled cycle.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-low; sampled on rising edge of CLK.
- PC_En  input  1  advance enable; 1 = update PC, 0 = stall (hold PC).
- Branch_Taken  input  1  redirect request from execute stage.
- Branch_Target  input  XLEN  redirect address, valid when Branch_Taken=1.
- PC_Out  output  XLEN  current PC (registered); instruction fetch address.
- PC_Plus4  output  XLEN  PC_Out + INCREMENT (combinational).
- PC_Next  output  XLEN  value the PC register loads on the next enabled edge (combinational, for debug/prefetch).

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-low (RST).
- Single PC register of XLEN bits, updated only on the rising edge of CLK.
- Priority on each rising edge, highest first:
  1. RST=0 -> PC_Out <= RESET_VECTOR, regardless of all other inputs.
  2. Branch_Taken=1 -> PC_Out <= {Branch_Target[XLEN-1:2], 2'b00}. This redirect overrides a stall (PC_En=0), so a resolved branch is never lost.
  3. PC_En=1 -> PC_Out <= PC_Plus4.
  4. Otherwise hold PC_Out.
- Adder: unsigned XLEN-bit addition, modulo 2^XLEN with no carry-out; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. Implemented as a separate combinational adder instance (A, B -> OUT) with B tied to INCREMENT.
- Branch target bits [1:0] are forced to 0; no misalignment exception is raised here.
- PC_Plus4 and PC_Next are purely combinational from PC_Out and inputs; zero latency.
- Latency: one cycle from the enabling edge to the new PC_Out.
- Reset value: PC_Out = RESET_VECTOR after the first rising edge with RST=0. PC_Plus4 then equals RESET_VECTOR+4.
- Before the first reset, PC_Out is undefined; the bench must apply reset first.
- Reset asserted mid-run: PC_Out returns to RESET_VECTOR on the next edge. Sequential counting resumes from RESET_VECTOR on the first edge after RST returns to 1 with PC_En=1.
- A stall of any length holds PC_Out exactly. On release, PC_Out resumes at held PC+4.
- No internal state other than the PC register.

Test Plan:
- Reset: RST=0 for 2 cycles with PC_En=1 and Branch_Taken=1 (target 32'h100) -> PC_Out=0 both cycles. Release RST=1 -> PC_Out = 4, 8, 12 on successive edges.
- Increment: after reset, 5 edges with PC_En=1 -> PC_Out=32'h14, PC_Plus4=32'h18. On every enabled edge, PC_Out equals the previous PC_Out + 4.
- Stall: at PC_Out=32'h10, PC_En=0 for 3 cycles -> PC_Out stays 32'h10. PC_En=1 -> next value 32'h14.
- Mid-run reset: at PC_Out=32'h20, drive RST=0 for 1 cycle -> PC_Out=0. Release -> counting resumes at 4.
- Branch: Branch_Taken=1, Branch_Target=32'h0000_1003, PC_En=0 -> PC_Out=32'h0000_1000 next edge. Then PC_En=1 -> 32'h0000_1004.
- Wrap: branch to 32'hFFFF_FFFC, then one enabled edge -> PC_Out=32'h0000_0000. While PC_Out=32'hFFFF_FFFC, PC_Plus4=32'h0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register with a PC+INCREMENT adder; a new PC appears one cycle after the enabling edge.
// Stall (PC_En=0) holds the PC; a branch redirect or a reset still loads during a stall.
module pc_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] OUT
);
  // Modulo 2^XLEN; carry-out intentionally dropped so the top address wraps to zero.
  assign OUT = A + B;
endmodule

module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INCREMENT    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PC_En,
  input  logic            Branch_Taken,
  input  logic [XLEN-1:0] Branch_Target,
  output logic [XLEN-1:0] PC_Out,
  output logic [XLEN-1:0] PC_Plus4,
  output logic [XLEN-1:0] PC_Next
);
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_incr;
  logic [XLEN-1:0] w_branch_aligned;

  assign w_incr           = XLEN'(INCREMENT);
  assign w_branch_aligned = {Branch_Target[XLEN-1:2], 2'b00};

  pc_adder #(.XLEN(XLEN)) u_adder (
    .A   (r_pc),
    .B   (w_incr),
    .OUT (w_pc_plus)
  );

  // Branch outranks stall so a resolved redirect is never dropped.
  always_comb begin
    w_pc_next = r_pc;
    if (!RST)
      w_pc_next = RESET_VECTOR;
    else if (Branch_Taken)
      w_pc_next = w_branch_aligned;
    else if (PC_En)
      w_pc_next = w_pc_plus;
  end

  always_ff @(posedge CLK) begin
    r_pc <= w_pc_next;
  end

  assign PC_Out   = r_pc;
  assign PC_Plus4 = w_pc_plus;
  assign PC_Next  = w_pc_next;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, increment, stall, mid-run reset, branch and wrap.
module tb_pc_fetch_unit;
  logic        CLK;
  logic        RST;
  logic        PC_En;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic [31:0] PC_Out;
  logic [31:0] PC_Plus4;
  logic [31:0] PC_Next;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .INCREMENT(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .PC_En         (PC_En),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .PC_Out        (PC_Out),
    .PC_Plus4      (PC_Plus4),
    .PC_Next       (PC_Next)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset_and_count(input int n);
    RST = 1'b0; PC_En = 1'b1; Branch_Taken = 1'b0;
    tick();
    RST = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; PC_En = 1'b1; Branch_Taken = 1'b1; Branch_Target = 32'h100;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (PC_Out !== 32'h0) $display("FAIL reset_hold%0d: PC_Out=%h expected %h", i, PC_Out, 32'h0);
      else pass_cnt++;
      total_cnt++;
    end
    if (PC_Plus4 !== 32'h4) $display("FAIL reset_plus4: PC_Plus4=%h expected %h", PC_Plus4, 32'h4);
    else pass_cnt++;
    total_cnt++;
    RST = 1'b1; Branch_Taken = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (PC_Out !== 32'(i * 4)) $display("FAIL reset_release%0d: PC_Out=%h expected %h", i, PC_Out, 32'(i * 4));
      else pass_cnt++;
      total_cnt++;
    end
  endtask

  task automatic test_increment();
    logic [31:0] prev;
    do_reset_and_count(0);
    prev = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (PC_Out !== prev + 32'h4) $display("FAIL incr_step%0d: PC_Out=%h expected %h", i, PC_Out, prev + 32'h4);
      else pass_cnt++;
      total_cnt++;
      prev = prev + 32'h4;
    end
    if (PC_Out !== 32'h14) $display("FAIL incr_final: PC_Out=%h expected %h", PC_Out, 32'h14);
    else pass_cnt++;
    total_cnt++;
    if (PC_Plus4 !== 32'h18) $display("FAIL incr_plus4: PC_Plus4=%h expected %h", PC_Plus4, 32'h18);
    else pass_cnt++;
    total_cnt++;
    if (PC_Next !== 32'h18) $display("FAIL incr_next: PC_Next=%h expected %h", PC_Next, 32'h18);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_stall();
    do_reset_and_count(4);
    if (PC_Out !== 32'h10) $display("FAIL stall_start: PC_Out=%h expected %h", PC_Out, 32'h10);
    else pass_cnt++;
    total_cnt++;
    PC_En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (PC_Out !== 32'h10) $display("FAIL stall_hold%0d: PC_Out=%h expected %h", i, PC_Out, 32'h10);
      else pass_cnt++;
      total_cnt++;
    end
    PC_En = 1'b1;
    tick();
    if (PC_Out !== 32'h14) $display("FAIL stall_release: PC_Out=%h expected %h", PC_Out, 32'h14);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset_and_count(8);
    if (PC_Out !== 32'h20) $display("FAIL midrst_start: PC_Out=%h expected %h", PC_Out, 32'h20);
    else pass_cnt++;
    total_cnt++;
    RST = 1'b0;
    tick();
    if (PC_Out !== 32'h0) $display("FAIL midrst_reset: PC_Out=%h expected %h", PC_Out, 32'h0);
    else pass_cnt++;
    total_cnt++;
    RST = 1'b1;
    tick();
    if (PC_Out !== 32'h4) $display("FAIL midrst_resume: PC_Out=%h expected %h", PC_Out, 32'h4);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_branch();
    do_reset_and_count(2);
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_1003; PC_En = 1'b0;
    #1;
    if (PC_Next !== 32'h0000_1000) $display("FAIL branch_next: PC_Next=%h expected %h", PC_Next, 32'h0000_1000);
    else pass_cnt++;
    total_cnt++;
    tick();
    if (PC_Out !== 32'h0000_1000) $display("FAIL branch_stalled: PC_Out=%h expected %h", PC_Out, 32'h0000_1000);
    else pass_cnt++;
    total_cnt++;
    Branch_Taken = 1'b0; PC_En = 1'b1;
    tick();
    if (PC_Out !== 32'h0000_1004) $display("FAIL branch_after: PC_Out=%h expected %h", PC_Out, 32'h0000_1004);
    else pass_cnt++;
    total_cnt++;
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_2002;
    tick();
    if (PC_Out !== 32'h0000_2000) $display("FAIL branch_enabled: PC_Out=%h expected %h", PC_Out, 32'h0000_2000);
    else pass_cnt++;
    total_cnt++;
    Branch_Taken = 1'b0;
  endtask

  task automatic test_wrap();
    Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFC; PC_En = 1'b1;
    tick();
    Branch_Taken = 1'b0;
    if (PC_Out !== 32'hFFFF_FFFC) $display("FAIL wrap_top: PC_Out=%h expected %h", PC_Out, 32'hFFFF_FFFC);
    else pass_cnt++;
    total_cnt++;
    #1;
    if (PC_Plus4 !== 32'h0) $display("FAIL wrap_plus4: PC_Plus4=%h expected %h", PC_Plus4, 32'h0);
    else pass_cnt++;
    total_cnt++;
    tick();
    if (PC_Out !== 32'h0) $display("FAIL wrap_pc: PC_Out=%h expected %h", PC_Out, 32'h0);
    else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    RST = 1'b0; PC_En = 1'b1; Branch_Taken = 1'b1; Branch_Target = 32'h100;
    test_reset();
    test_increment();
    test_stall();
    test_mid_reset();
    test_branch();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
